// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes rstN release, stretches sync_reset for HOLD_CYCLES and
// services software reset requests. Define RST_WATCHDOG_EN to build the watchdog.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8,
  parameter int WDT_CYCLES  = 200
) (
  input  logic       clock,
  input  logic       rstN,
  input  logic       sw_reset_req,
  input  logic       wdt_kick,
  output logic       sync_reset,
  output logic       reset_done,
  output logic       sw_reset_ack,
  output logic [1:0] reset_cause
);

  typedef enum logic [1:0] {
    SYNC = 2'b00,
    HOLD = 2'b01,
    RUN  = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Software/watchdog holds last one extra cycle so the request cycle itself is
  // covered: downstream sees HOLD_CYCLES+1 cycles of reset.
  localparam logic [CNT_W-1:0] HOLD_POR_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_SOFT_LAST = CNT_W'(HOLD_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cause_nxt;
  logic             ack_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             rel;
  logic             req_q;
  logic             sw_edge;
  logic             wdt_exp;
  logic [CNT_W-1:0] hold_last;

  // Release synchronizer
  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rel = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      req_q <= 1'b0;
    end else begin
      req_q <= sw_reset_req;
    end
  end

  assign sw_edge = sw_reset_req & ~req_q;

`ifdef RST_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

  logic [CNT_W-1:0] wdt_cnt, wdt_cnt_nxt;

  always_comb begin
    wdt_cnt_nxt = '0;
    wdt_exp     = 1'b0;
    if (state == RUN && !wdt_kick) begin
      if (wdt_cnt == WDT_LAST) begin
        wdt_exp = 1'b1;
      end else begin
        wdt_cnt_nxt = wdt_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt_nxt;
    end
  end
`else
  logic wdt_kick_unused;
  assign wdt_kick_unused = wdt_kick;
  assign wdt_exp         = 1'b0;
`endif

  assign hold_last = (reset_cause == CAUSE_POR) ? HOLD_POR_LAST : HOLD_SOFT_LAST;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = reset_cause;
    ack_nxt   = 1'b0;
    case (state)
      SYNC: begin
        cnt_nxt = '0;
        if (rel) state_nxt = HOLD;
      end
      HOLD: begin
        if (cnt == hold_last) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_nxt = '0;
        // Software request takes priority over a same-edge watchdog expiry
        if (sw_edge) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_SW;
          ack_nxt   = 1'b1;
        end else if (wdt_exp) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_WDT;
        end
      end
      default: begin
        state_nxt = SYNC;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      state        <= SYNC;
      cnt          <= '0;
      sync_reset   <= 1'b1;
      reset_done   <= 1'b0;
      sw_reset_ack <= 1'b0;
      reset_cause  <= CAUSE_POR;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sync_reset   <= (state_nxt != RUN);
      reset_done   <= (state_nxt == RUN);
      sw_reset_ack <= ack_nxt;
      reset_cause  <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them. Watchdog tests run when RST_WATCHDOG_EN is set.
module tb_reset_sequencer;

  logic       clock;
  logic       rstN;
  logic       sw_reset_req;
  logic       wdt_kick;
  logic       sync_reset;
  logic       reset_done;
  logic       sw_reset_ack;
  logic [1:0] reset_cause;

  reset_sequencer #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(16),
    .CNT_W(8),
    .WDT_CYCLES(200)
  ) dut (
    .clock(clock),
    .rstN(rstN),
    .sw_reset_req(sw_reset_req),
    .wdt_kick(wdt_kick),
    .sync_reset(sync_reset),
    .reset_done(reset_done),
    .sw_reset_ack(sw_reset_ack),
    .reset_cause(reset_cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  v;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // {sync_reset, reset_done, sw_reset_ack, reset_cause}
  localparam logic [4:0] V_RST    = 5'b1_0_0_00;
  localparam logic [4:0] V_RUN00  = 5'b0_1_0_00;
  localparam logic [4:0] V_RUN01  = 5'b0_1_0_01;
  localparam logic [4:0] V_ACK01  = 5'b1_0_1_01;
  localparam logic [4:0] V_HOLD01 = 5'b1_0_0_01;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t       e;
      logic [4:0] got;
      e   = sbq.pop_front();
      got = {sync_reset, reset_done, sw_reset_ack, reset_cause};
      n_tests++;
      if (e.cyc != cyc || got !== e.v) begin
        n_fail++;
        $display("FAIL %s cyc=%0d (exp cyc %0d): got sr=%b done=%b ack=%b cause=%b, want sr=%b done=%b ack=%b cause=%b",
                 e.tag, cyc, e.cyc, got[4], got[3], got[2], got[1:0],
                 e.v[4], e.v[3], e.v[2], e.v[1:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_span(input int unsigned a, input int unsigned b,
                           input logic [4:0] v, input string tag);
    for (int unsigned i = a; i <= b; i++) begin
      exp_t e;
      e.cyc = i;
      e.v   = v;
      e.tag = tag;
      sbq.push_back(e);
    end
  endtask

  // Release happened mid-cycle R; first edge after release is R+1.
  task automatic power_on_expect(input int unsigned r, input int unsigned run_n, input string tag);
    push_span(r + 1, r + 18, V_RST, tag);
    push_span(r + 19, r + 18 + run_n, V_RUN00, tag);
  endtask

  initial begin
    int unsigned c;
    int unsigned r;
    rstN         = 1'b0;
    sw_reset_req = 1'b0;
    wdt_kick     = 1'b0;

    // Power-on: rstN low 5 cycles, released mid-cycle
    tick(1);
    push_span(cyc + 1, cyc + 5, V_RST, "por_held");
    tick(5);
    #2 rstN = 1'b1;
    r = cyc;
    power_on_expect(r, 4, "por_seq");
    tick(22);

    // Software request held high 40 cycles: one ack, 17 reset cycles, no retrigger
    c = cyc;
    sw_reset_req = 1'b1;
    push_span(c + 1, c + 1, V_ACK01, "sw_ack");
    push_span(c + 2, c + 17, V_HOLD01, "sw_hold");
    push_span(c + 18, c + 45, V_RUN01, "sw_run_no_retrig");
    tick(40);
    sw_reset_req = 1'b0;
    tick(5);

    // rstN during software hold at cnt=7
    c = cyc;
    sw_reset_req = 1'b1;
    push_span(c + 1, c + 1, V_ACK01, "sw2_ack");
    push_span(c + 2, c + 7, V_HOLD01, "sw2_hold");
    push_span(c + 8, c + 11, V_RST, "async_mid_hold");
    tick(1);
    sw_reset_req = 1'b0;
    tick(7);
    rstN = 1'b0;
    tick(3);
    #2 rstN = 1'b1;
    r = cyc;
    power_on_expect(r, 4, "por_after_abort");
    tick(22);

    // Requests during SYNC and HOLD are ignored
    c = cyc;
    push_span(c + 1, c + 3, V_RST, "por3_held");
    tick(1);
    rstN = 1'b0;
    tick(2);
    #2 rstN = 1'b1;
    r = cyc;
    power_on_expect(r, 10, "req_ignored");
    tick(1);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    tick(6);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    tick(19);

`ifdef RST_WATCHDOG_EN
    begin
      int unsigned k;
      c = cyc;
      k = c + 6 * 150 + 1;
      push_span(c + 1, k + 199, V_RUN00, "wdt_kicked");
      push_span(k + 200, k + 216, 5'b1_0_0_10, "wdt_expire");
      push_span(k + 217, k + 416, 5'b0_1_0_10, "wdt_run");
      push_span(k + 417, k + 417, V_ACK01, "sw_beats_wdt");
      push_span(k + 418, k + 433, V_HOLD01, "sw_beats_wdt_hold");
      push_span(k + 434, k + 437, V_RUN01, "sw_beats_wdt_run");
      for (int i = 0; i < 7; i++) begin
        wdt_kick = 1'b1;
        tick(1);
        wdt_kick = 1'b0;
        tick(149);
      end
      tick(int'((k + 416) - cyc));
      sw_reset_req = 1'b1;
      tick(1);
      sw_reset_req = 1'b0;
      tick(21);
    end
`else
    c = cyc;
    push_span(c + 1, c + 5000, V_RUN00, "no_wdt");
    tick(5000);
`endif

    tick(2);
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Reset sequencer that produces the synchronous active-high reset consumed by downstream flops with synchronous reset (e.g. the single-bit synchronous-reset register stage). It takes the board-level asynchronous active-low reset, synchronizes its release, stretches it for a programmable hold time, and supports software-requested resets. It also reports completion and the reset cause.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on rstN release (legal >= 2)
HOLD_CYCLES, 16, cycles sync_reset stays high after synchronized release or after a sw request (legal 1..2^CNT_W-1)
CNT_W, 8, hold/watchdog counter width
WDT_CYCLES, 200, watchdog timeout in cycles (used only with the optional feature; legal <= 2^CNT_W-1)

Ports:
clock  input  1  single clock, rising edge
rstN  input  1  asynchronous active-low reset; assertion is async, release is synchronized internally
sw_reset_req  input  1  software reset request; rising edge detected
wdt_kick  input  1  watchdog restart pulse; ignored unless RST_WATCHDOG_EN
sync_reset  output  1  synchronous active-high reset to downstream stages
reset_done  output  1  high while in RUN
sw_reset_ack  output  1  one-cycle pulse when a sw request is accepted
reset_cause  output  2  00 power-on/rstN, 01 software, 10 watchdog, 11 unused

Behaviour:
- Reset: rstN low immediately forces state=SYNC, sync chain=0, cnt=0, req edge register=0, sync_reset=1, reset_done=0, sw_reset_ack=0, reset_cause=00. rstN low overrides every other event at all times, including mid-HOLD.
- Synchronizer: SYNC_STAGES flops shift in 1 after rstN rises. Output rel goes high at edge SYNC_STAGES after release.
- FSM states: SYNC, HOLD, RUN. 2-bit encoding. The unused encoding goes to SYNC on the next edge with sync_reset=1.
- SYNC: on the edge where rel=1, go to HOLD with cnt=0.
- HOLD: cnt increments each edge. On the edge where cnt==HOLD_CYCLES-1, go to RUN and clear cnt.
- RUN: sync_reset=0 and reset_done=1, both registered and glitch-free.
- Power-on latency: sync_reset falls at edge SYNC_STAGES+HOLD_CYCLES+1 counted from the first rising edge after rstN release. With defaults this is edge 19.
- Software reset: in RUN, a rising edge of sw_reset_req (registered previous value 0, current 1) causes the following at the next edge:
  - go to HOLD with cnt=0
  - sync_reset=1, reset_done=0
  - reset_cause=01
  - sw_reset_ack=1 for exactly one cycle
  The request is level-insensitive, so holding it high does not retrigger. Requests outside RUN are ignored and not queued.
- sync_reset stays high for exactly HOLD_CYCLES+1 cycles after a software reset.
- reset_cause holds its value until the next reset event. rstN always sets it to 00.
- Same-edge sw request and watchdog expiry: the software request wins (cause=01).

Optional Feature:
RST_WATCHDOG_EN. When defined:
- A watchdog counter runs only in RUN and is cleared on entering RUN and on wdt_kick=1.
- If the counter reaches WDT_CYCLES-1 without a kick, the next edge goes to HOLD with sync_reset=1, reset_done=0, reset_cause=10. There is no ack pulse.

When undefined: no watchdog logic is built, wdt_kick is ignored, and reset_cause never equals 10. The port list is identical in both builds.

Test Plan:
1. rstN low 5 cycles, then released mid-cycle -> sync_reset=1, reset_done=0, cause=00 throughout; sync_reset falls after edge 19; reset_done rises the same edge.
2. In RUN, sw_reset_req held high 40 cycles -> one ack pulse, cause=01, sync_reset high exactly 17 cycles, then RUN; no second reset.
3. rstN pulsed low at HOLD cnt=7 during a sw reset -> outputs immediately return to reset values; cause=00; full 19-edge sequence repeats.
4. sw_reset_req pulsed during SYNC and during HOLD -> ignored; no ack; power-on timing unchanged.
5. With RST_WATCHDOG_EN, kick every 150 cycles for 1000 cycles -> no reset. Then stop kicking -> sync_reset rises at 200 cycles after the last kick, cause=10.
6. Without RST_WATCHDOG_EN, no kicks for 5000 cycles -> sync_reset stays 0 and reset_done stays 1.
